mbist_march_ctrl: RTL and testbench

MBIST sequencer that drives the pattern data generator (`DATA_EN`, `gen_Turn`, `PAT_SEL`) and the SRAM under test. It walks the march elements of the selected algorithm, issues read/write accesses per address in the required direction, compares read data against the expected pattern, and reports pass/fail with the first failing address and turn. It sits between the BIST top-level start/status registers and the data generator plus SRAM port.

---
 rtl/mbist_march_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: march-test sequencer for a single-port synchronous SRAM.
// It walks the elements of the selected algorithm (MSCAN or March C), drives the
// pattern generator (DATA_EN / gen_Turn / PAT_SEL_O), and issues one SRAM access
// per cycle. Each read is compared one cycle later, and the first mismatch is
// captured in FAIL / FAIL_ADDR / FAIL_TURN.
// Optional feature: define MBIST_STOP_ON_FAIL_EN to abort to DONE on the first
// mismatch. Without it, the full sequence always runs.
// Handshake: START is a single-cycle request. It is honoured only in IDLE or
// DONE and ignored while BUSY. DONE is a level that holds until the next START.
module mbist_march_ctrl #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic [2:0]        PAT_SEL,
   input  logic [DATA_W-1:0] GEN_DATA,
   output logic              DATA_EN,
   output logic [3:0]        gen_Turn,
   output logic [2:0]        PAT_SEL_O,
   output logic              SRAM_CS,
   output logic              SRAM_WE,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic [DATA_W-1:0] SRAM_WDATA,
   input  logic [DATA_W-1:0] SRAM_RDATA,
   output logic              BUSY,
   output logic              DONE,
   output logic              FAIL,
   output logic [ADDR_W-1:0] FAIL_ADDR,
   output logic [3:0]        FAIL_TURN
);

   localparam logic [2:0]        PAT_MSCAN   = 3'd0;
   localparam logic [2:0]        PAT_MARCH_C = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_MAX    = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_PREP, S_SETTLE, S_ACC, S_DRAIN, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          turn_q;
   logic [2:0]          pat_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                op_q;        // 0 = first op of the address, 1 = second
   logic [DATA_W-1:0]   exp_q;       // value the current element's reads expect
   logic                pend_q;      // a read was issued last cycle
   logic [DATA_W-1:0]   pend_exp_q;
   logic [ADDR_W-1:0]   pend_addr_q;
   logic [3:0]          pend_turn_q;
   logic                fail_q;
   logic [ADDR_W-1:0]   fail_addr_q;
   logic [3:0]          fail_turn_q;

   logic el_two_ops, el_first_rd, el_down, el_last;
   logic op_is_wr, op_last, el_has_wr, addr_end, elem_end;
   logic pat_ok, mismatch, fail_set, busy_st;

   // Element decode: shape of the current element for the latched algorithm.
   always_comb begin
      el_two_ops  = 1'b0;
      el_first_rd = 1'b0;
      el_down     = 1'b0;
      el_last     = 1'b0;
      if (pat_q == PAT_MARCH_C) begin
         el_two_ops  = (turn_q >= 4'd2) && (turn_q <= 4'd5);
         el_first_rd = (turn_q >= 4'd2);
         el_down     = (turn_q >= 4'd4);
         el_last     = (turn_q == 4'd6);
      end else begin
         // MSCAN: odd elements write, even elements read, all ascending
         el_first_rd = ~turn_q[0];
         el_last     = (turn_q == 4'd4);
      end
   end

   assign op_is_wr  = el_two_ops ? op_q : ~el_first_rd;
   assign op_last   = el_two_ops ? op_q : 1'b1;
   assign el_has_wr = el_two_ops | ~el_first_rd;
   assign addr_end  = el_down ? (addr_q == '0) : (addr_q == ADDR_MAX);
   assign elem_end  = (state_q == S_ACC) && op_last && addr_end;
   assign pat_ok    = (PAT_SEL == PAT_MSCAN) || (PAT_SEL == PAT_MARCH_C);
   assign mismatch  = pend_q && (SRAM_RDATA != pend_exp_q);
   assign fail_set  = mismatch && !fail_q;
   assign busy_st   = (state_q == S_PREP) || (state_q == S_SETTLE) ||
                      (state_q == S_ACC)  || (state_q == S_DRAIN);

   // Next-state logic and state-decoded outputs.
   always_comb begin
      state_d = state_q;
      DATA_EN = (state_q == S_PREP);
      SRAM_CS = (state_q == S_ACC);
      SRAM_WE = (state_q == S_ACC) && op_is_wr;
      BUSY    = busy_st;
      DONE    = (state_q == S_DONE);
      case (state_q)
         S_IDLE, S_DONE: if (START) state_d = pat_ok ? S_PREP : S_DONE;
         S_PREP:         state_d = S_SETTLE;
         S_SETTLE:       state_d = S_ACC;
         S_ACC:          if (elem_end) state_d = el_last ? S_DRAIN : S_PREP;
         S_DRAIN:        state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
`ifdef MBIST_STOP_ON_FAIL_EN
      if (fail_set && busy_st) state_d = S_DONE;
`endif
   end

   // State register plus the address/element counters, expected data and fail capture.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         turn_q      <= 4'd0;
         pat_q       <= 3'd0;
         addr_q      <= '0;
         op_q        <= 1'b0;
         exp_q       <= '0;
         pend_q      <= 1'b0;
         pend_exp_q  <= '0;
         pend_addr_q <= '0;
         pend_turn_q <= 4'd0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_turn_q <= 4'd0;
      end else begin
         state_q <= state_d;

         // The compare of last cycle's read; only the first mismatch is kept.
         if (fail_set) begin
            fail_q      <= 1'b1;
            fail_addr_q <= pend_addr_q;
            fail_turn_q <= pend_turn_q;
         end

         // Register a pending compare for every read that is actually issued.
         pend_q      <= (state_q == S_ACC) && !op_is_wr && (state_d != S_DONE);
         pend_exp_q  <= exp_q;
         pend_addr_q <= addr_q;
         pend_turn_q <= turn_q;

         case (state_q)
            S_IDLE, S_DONE: begin
               if (START) begin
                  fail_addr_q <= '0;
                  fail_turn_q <= 4'd0;
                  if (pat_ok) begin
                     pat_q  <= PAT_SEL;
                     turn_q <= 4'd1;
                     fail_q <= 1'b0;
                  end else begin
                     fail_q <= 1'b1;
                  end
               end
            end
            S_SETTLE: begin
               addr_q <= el_down ? ADDR_MAX : '0;
               op_q   <= 1'b0;
            end
            S_ACC: begin
               if (op_last) begin
                  op_q <= 1'b0;
                  // hold the address at the last one of the element: never wrap
                  if (!addr_end) addr_q <= el_down ? addr_q - ADDR_ONE : addr_q + ADDR_ONE;
               end else begin
                  op_q <= 1'b1;
               end
               if (elem_end) begin
                  if (el_has_wr) exp_q <= GEN_DATA;
                  if (!el_last) turn_q <= turn_q + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign gen_Turn   = turn_q;
   assign PAT_SEL_O  = pat_q;
   assign SRAM_ADDR  = addr_q;
   assign SRAM_WDATA = GEN_DATA;
   assign FAIL       = fail_q;
   assign FAIL_ADDR  = fail_addr_q;
   assign FAIL_TURN  = fail_turn_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: directed bench for mbist_march_ctrl with a behavioural
// pattern generator and a 16x8 synchronous SRAM that has an optional bit0
// stuck-at-0 at address 5.
module tb_mbist_march_ctrl;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       START;
   logic [2:0] PAT_SEL;
   logic [7:0] GEN_DATA = 8'h5A;
   logic       DATA_EN;
   logic [3:0] gen_Turn;
   logic [2:0] PAT_SEL_O;
   logic       SRAM_CS, SRAM_WE;
   logic [3:0] SRAM_ADDR;
   logic [7:0] SRAM_WDATA;
   logic [7:0] SRAM_RDATA;
   logic       BUSY, DONE, FAIL;
   logic [3:0] FAIL_ADDR, FAIL_TURN;

   logic       fault_en;
   logic [7:0] mem [16];

   int n_checks = 0;
   int n_errors = 0;

   // run results
   int          r_busy, r_de, r_done_lat, r_cs_after_fail;
   logic        r_fail_first, r_fail_seen, r_done_at_fail;
   logic [16:0] act_q[$];
   logic [16:0] exp_q[$];
   logic [3:0]  turn_q[$];

   mbist_march_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .PAT_SEL(PAT_SEL),
      .GEN_DATA(GEN_DATA), .DATA_EN(DATA_EN), .gen_Turn(gen_Turn),
      .PAT_SEL_O(PAT_SEL_O), .SRAM_CS(SRAM_CS), .SRAM_WE(SRAM_WE),
      .SRAM_ADDR(SRAM_ADDR), .SRAM_WDATA(SRAM_WDATA), .SRAM_RDATA(SRAM_RDATA),
      .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL), .FAIL_ADDR(FAIL_ADDR),
      .FAIL_TURN(FAIL_TURN)
   );

   // clock / reset block
   always #5 CLK = ~CLK;

   // Pattern value written in element t: MSCAN w00 .. w01, March C w0 r0w1 r1w0 r0w1 r1w0 r0
   function automatic logic [7:0] gen_f(input logic [2:0] pat, input logic [3:0] t);
      if (pat == 3'd0) return (t >= 4'd3) ? 8'h01 : 8'h00;
      return t[0] ? 8'h00 : 8'h01;
   endfunction

   // generator model: new value one edge after the DATA_EN strobe
   always @(posedge CLK) if (DATA_EN) GEN_DATA <= gen_f(PAT_SEL_O, gen_Turn);

   // SRAM model with optional stuck-at-0 on bit0 of word 5
   always @(posedge CLK) begin
      if (SRAM_CS && SRAM_WE)
         mem[SRAM_ADDR] <= (fault_en && SRAM_ADDR == 4'd5) ? (SRAM_WDATA & 8'hFE) : SRAM_WDATA;
      if (SRAM_CS && !SRAM_WE) SRAM_RDATA <= mem[SRAM_ADDR];
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, act, exp);
      end
   endtask

   // expected access stream {turn, we, addr, wdata(0 for reads)}
   task automatic build_exp(input logic [2:0] pat);
      int n_el;
      logic rd, wr, down;
      logic [3:0] a;
      exp_q.delete();
      n_el = (pat == 3'd0) ? 4 : 6;
      for (int t = 1; t <= n_el; t++) begin
         if (pat == 3'd0) begin
            wr = (t % 2) == 1; rd = !wr; down = 1'b0;
         end else begin
            rd = t >= 2; wr = t <= 5; down = t >= 4;
         end
         for (int k = 0; k < 16; k++) begin
            a = down ? 4'(15 - k) : 4'(k);
            if (rd) exp_q.push_back({4'(t), 1'b0, a, 8'h00});
            if (wr) exp_q.push_back({4'(t), 1'b1, a, gen_f(pat, 4'(t))});
         end
      end
   endtask

   task automatic cmp_seq(input string tag);
      chk({tag, "_len"}, 32'(act_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
         chk($sformatf("%s_acc%0d", tag, i), 32'(act_q[i]), 32'(exp_q[i]));
   endtask

   task automatic chk_turns(input string tag, input int n);
      chk({tag, "_de_cnt"}, 32'(r_de), 32'(n));
      for (int i = 0; i < turn_q.size() && i < n; i++)
         chk($sformatf("%s_turn%0d", tag, i), 32'(turn_q[i]), 32'(i + 1));
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_data_en"}, 32'(DATA_EN), 0);
      chk({tag, "_turn"}, 32'(gen_Turn), 0);
      chk({tag, "_pat_o"}, 32'(PAT_SEL_O), 0);
      chk({tag, "_cs"}, 32'(SRAM_CS), 0);
      chk({tag, "_we"}, 32'(SRAM_WE), 0);
      chk({tag, "_addr"}, 32'(SRAM_ADDR), 0);
      chk({tag, "_wdata"}, 32'(SRAM_WDATA), 32'(GEN_DATA));
      chk({tag, "_busy"}, 32'(BUSY), 0);
      chk({tag, "_done"}, 32'(DONE), 0);
      chk({tag, "_fail"}, 32'(FAIL), 0);
      chk({tag, "_fail_addr"}, 32'(FAIL_ADDR), 0);
      chk({tag, "_fail_turn"}, 32'(FAIL_TURN), 0);
   endtask

   // driver + monitor: pulse START, then sample every negedge until DONE (bounded)
   task automatic run_test(input string tag, input logic [2:0] pat, input int restart_at);
      act_q.delete(); turn_q.delete();
      r_busy = 0; r_de = 0; r_done_lat = 0; r_cs_after_fail = 0;
      r_fail_first = 1'b0; r_fail_seen = 1'b0; r_done_at_fail = 1'b0;
      @(negedge CLK);
      PAT_SEL = pat;
      START   = 1'b1;
      for (int i = 1; i <= 400; i++) begin
         @(negedge CLK);
         START = (i == restart_at);
         if (i == 1) r_fail_first = FAIL;
         if (BUSY) r_busy++;
         if (DATA_EN) begin r_de++; turn_q.push_back(gen_Turn); end
         if (SRAM_CS) begin
            act_q.push_back({gen_Turn, SRAM_WE, SRAM_ADDR, SRAM_WE ? SRAM_WDATA : 8'h00});
            if (r_fail_seen) r_cs_after_fail++;
         end
         if (FAIL && !r_fail_seen) begin r_fail_seen = 1'b1; r_done_at_fail = DONE; end
         if (DONE) begin r_done_lat = i; break; end
      end
      START = 1'b0;
      chk({tag, "_done_seen"}, 32'(r_done_lat != 0), 1);
   endtask

   initial begin
      int  k;
      logic found;
      RESET = 1'b1; START = 1'b0; PAT_SEL = 3'd0; fault_en = 1'b0;
      repeat (3) @(negedge CLK);
      chk_reset_outs("rst");
      RESET = 1'b0;

      // MSCAN, fault-free
      run_test("mscan", 3'd0, 0);
      chk("mscan_busy", 32'(r_busy), 73);
      chk("mscan_done_lat", 32'(r_done_lat), 74);
      chk("mscan_fail", 32'(FAIL), 0);
      chk_turns("mscan", 4);
      build_exp(3'd0);
      cmp_seq("mscan");

      // March C, fault-free
      run_test("mc", 3'd2, 0);
      chk("mc_busy", 32'(r_busy), 173);
      chk("mc_done_lat", 32'(r_done_lat), 174);
      chk("mc_fail", 32'(FAIL), 0);
      chk("mc_pat_o", 32'(PAT_SEL_O), 2);
      chk_turns("mc", 6);
      build_exp(3'd2);
      cmp_seq("mc");

      // March C, bit0 stuck-at-0 at address 5
      fault_en = 1'b1;
      run_test("flt", 3'd2, 0);
      chk("flt_fail", 32'(FAIL), 1);
      chk("flt_fail_addr", 32'(FAIL_ADDR), 5);
      chk("flt_fail_turn", 32'(FAIL_TURN), 3);
`ifdef MBIST_STOP_ON_FAIL_EN
      chk("flt_busy", 32'(r_busy), 66);
      chk("flt_done_at_fail", 32'(r_done_at_fail), 1);
      chk("flt_cs_after_fail", 32'(r_cs_after_fail), 0);
`else
      chk("flt_busy", 32'(r_busy), 173);
      chk("flt_done_at_fail", 32'(r_done_at_fail), 0);
`endif

      // START in DONE clears the capture; a START while BUSY is ignored
      fault_en = 1'b0;
      run_test("rst_busy", 3'd2, 50);
      chk("rst_busy_fail_cleared", 32'(r_fail_first), 0);
      chk("rst_busy_busy", 32'(r_busy), 173);
      chk("rst_busy_fail", 32'(FAIL), 0);
      chk("rst_busy_fail_addr", 32'(FAIL_ADDR), 0);
      chk("rst_busy_fail_turn", 32'(FAIL_TURN), 0);
      cmp_seq("rst_busy");

      // unsupported algorithm
      run_test("unsup", 3'd1, 0);
      chk("unsup_done_lat", 32'(r_done_lat), 1);
      chk("unsup_busy", 32'(r_busy), 0);
      chk("unsup_fail", 32'(FAIL), 1);
      chk("unsup_fail_turn", 32'(FAIL_TURN), 0);
      chk("unsup_cs_cnt", 32'(act_q.size()), 0);

      // RESET during March C element 3, then a clean rerun
      @(negedge CLK);
      PAT_SEL = 3'd2;
      START = 1'b1;
      found = 1'b0;
      k = 0;
      while (!found && k < 300) begin
         @(negedge CLK);
         START = 1'b0;
         k++;
         if (gen_Turn == 4'd3 && SRAM_CS) found = 1'b1;
      end
      chk("mid_el3_reached", 32'(found), 1);
      RESET = 1'b1;
      @(negedge CLK);
      chk_reset_outs("mid_rst");
      RESET = 1'b0;
      run_test("rerun", 3'd2, 0);
      chk("rerun_busy", 32'(r_busy), 173);
      chk("rerun_fail", 32'(FAIL), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
